// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: registers the stage-1 ALU op, decodes it into the ALU
// control word, and splits 16-bit add/sub into chained low/high byte steps.
module alu_op_sequencer #(
    parameter logic RESET_FLAGC = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Hold,
    input  logic       OpValid,
    input  logic [3:0] AluOp,
    input  logic       AluCarryOut,
    output logic       Stall,
    output logic       AluClockEn,
    output logic       AluActive,
    output logic       AluWrite,
    output logic       AluHighByte,
    output logic [7:0] AluCtrl,
    output logic       ChainCarry,
    output logic       FlagC
);

    typedef enum logic {
        IDLE = 1'b0,
        HI16 = 1'b1
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_ADC   = 4'd2,
        OP_SUB   = 4'd3,
        OP_SBC   = 4'd4,
        OP_AND   = 4'd5,
        OP_OR    = 4'd6,
        OP_XOR   = 4'd7,
        OP_NOT   = 4'd8,
        OP_SHL   = 4'd9,
        OP_SHR   = 4'd10,
        OP_INC   = 4'd11,
        OP_DEC   = 4'd12,
        OP_ADD16 = 4'd13,
        OP_SUB16 = 4'd14,
        OP_CMP   = 4'd15
    } alu_op_t;

    state_t      state;
    logic [7:0]  hi_ctrl;      // high-step word held across the stall cycle
    logic        flag_upd;     // current cycle's carry out belongs in FlagC

    logic [7:0]  dec_ctrl;
    logic [7:0]  dec_hi_ctrl;
    logic        dec_sets_c;
    logic        dec_write;
    logic        dec_is16;
    logic        op_valid;

    // Combinational decode of the incoming op into control word and attributes
    always_comb begin
        dec_ctrl    = '0;
        dec_hi_ctrl = '0;
        dec_sets_c  = 1'b0;
        dec_write   = 1'b1;
        dec_is16    = 1'b0;
        case (alu_op_t'(AluOp))
            OP_ADD:   begin dec_ctrl = 8'h0A; dec_sets_c = 1'b1; end
            OP_ADC:   begin dec_ctrl = 8'h8A; dec_sets_c = 1'b1; end
            OP_SUB:   begin dec_ctrl = 8'h45; dec_sets_c = 1'b1; end
            OP_SBC:   begin dec_ctrl = 8'h85; dec_sets_c = 1'b1; end
            OP_AND:   dec_ctrl = 8'h18;
            OP_OR:    dec_ctrl = 8'h1E;
            OP_XOR:   dec_ctrl = 8'h16;
            OP_NOT:   dec_ctrl = 8'h10;
            OP_SHL:   begin dec_ctrl = 8'h2F; dec_sets_c = 1'b1; end
            OP_SHR:   begin dec_ctrl = 8'h30; dec_sets_c = 1'b1; end
            OP_INC:   begin dec_ctrl = 8'h40; dec_sets_c = 1'b1; end
            OP_DEC:   begin dec_ctrl = 8'h0F; dec_sets_c = 1'b1; end
            OP_ADD16: begin dec_ctrl = 8'h0A; dec_hi_ctrl = 8'hCA; dec_is16 = 1'b1; end
            OP_SUB16: begin dec_ctrl = 8'h45; dec_hi_ctrl = 8'hC5; dec_is16 = 1'b1; end
            OP_CMP:   begin dec_ctrl = 8'h45; dec_sets_c = 1'b1; dec_write = 1'b0; end
            default:  begin dec_ctrl = '0; dec_write = 1'b0; end
        endcase
        op_valid = OpValid && (AluOp != OP_NOP);
    end

    // Sequencer state, registered ALU controls, chain carry and carry flag
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            hi_ctrl     <= '0;
            flag_upd    <= 1'b0;
            Stall       <= 1'b0;
            AluClockEn  <= 1'b0;
            AluActive   <= 1'b0;
            AluWrite    <= 1'b0;
            AluHighByte <= 1'b0;
            AluCtrl     <= '0;
            ChainCarry  <= 1'b0;
            FlagC       <= RESET_FLAGC;
        end else if (!Hold) begin
            // flag_upd describes the cycle ending at this edge, independent of state
            if (flag_upd) begin
                FlagC <= AluCarryOut;
            end
            case (state)
                IDLE: begin
                    AluHighByte <= 1'b0;
                    if (op_valid) begin
                        AluCtrl    <= dec_ctrl;
                        AluActive  <= 1'b1;
                        AluClockEn <= 1'b1;
                        AluWrite   <= dec_write;
                        if (dec_is16) begin
                            hi_ctrl  <= dec_hi_ctrl;
                            Stall    <= 1'b1;
                            flag_upd <= 1'b0;
                            state    <= HI16;
                        end else begin
                            Stall    <= 1'b0;
                            flag_upd <= dec_sets_c;
                        end
                    end else begin
                        AluCtrl    <= '0;
                        AluActive  <= 1'b0;
                        AluClockEn <= 1'b0;
                        AluWrite   <= 1'b0;
                        Stall      <= 1'b0;
                        flag_upd   <= 1'b0;
                    end
                end
                HI16: begin
                    ChainCarry  <= AluCarryOut;
                    AluCtrl     <= hi_ctrl;
                    AluActive   <= 1'b1;
                    AluClockEn  <= 1'b1;
                    AluWrite    <= 1'b1;
                    AluHighByte <= 1'b1;
                    Stall       <= 1'b0;
                    flag_upd    <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios followed by
// random traffic, compared against a table-driven behavioural model.
module tb_alu_op_sequencer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Hold;
    logic       OpValid;
    logic [3:0] AluOp;
    logic       AluCarryOut;
    logic       Stall, AluClockEn, AluActive, AluWrite, AluHighByte;
    logic [7:0] AluCtrl;
    logic       ChainCarry, FlagC;

    int errors = 0;
    int checks = 0;

    alu_op_sequencer #(.RESET_FLAGC(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .Hold(Hold), .OpValid(OpValid),
        .AluOp(AluOp), .AluCarryOut(AluCarryOut), .Stall(Stall),
        .AluClockEn(AluClockEn), .AluActive(AluActive), .AluWrite(AluWrite),
        .AluHighByte(AluHighByte), .AluCtrl(AluCtrl),
        .ChainCarry(ChainCarry), .FlagC(FlagC)
    );

    always #5 Clock = ~Clock;

    // Model of what is visible in the current cycle.
    logic [7:0] e_ctrl;
    logic       e_stall, e_clken, e_active, e_write, e_high, e_chain, e_flagc;
    int         cyc_op;          // op whose step is displayed (-1 none)
    bit         cyc_is_hi;       // displayed step is a 16-bit high step
    int         pend_hi_op;      // 16-bit op awaiting its high step (-1 none)

    function automatic logic [7:0] lo_word(input int op);
        logic [7:0] t [16] = '{8'h00, 8'h0A, 8'h8A, 8'h45, 8'h85, 8'h18, 8'h1E, 8'h16,
                               8'h10, 8'h2F, 8'h30, 8'h40, 8'h0F, 8'h0A, 8'h45, 8'h45};
        return t[op];
    endfunction

    function automatic bit carry_op(input int op, input bit hi);
        if (op == 13 || op == 14) return hi;
        return (op >= 1 && op <= 4) || (op >= 9 && op <= 12) || op == 15;
    endfunction

    function automatic void show(input int op, input bit hi);
        cyc_op    = op;
        cyc_is_hi = hi;
        if (op < 0) begin
            e_ctrl = 8'h00; e_active = 0; e_clken = 0; e_write = 0; e_high = 0; e_stall = 0;
        end else begin
            e_ctrl   = hi ? (op == 13 ? 8'hCA : 8'hC5) : lo_word(op);
            e_active = 1; e_clken = 1; e_write = (op != 15); e_high = hi;
            e_stall  = (op == 13 || op == 14) && !hi;
        end
    endfunction

    function automatic void model_reset();
        show(-1, 0);
        pend_hi_op = -1;
        e_chain    = 0;
        e_flagc    = 1;
    endfunction

    // Advance the model across one rising edge with the inputs as driven.
    function automatic void model_edge();
        if (Reset) begin
            model_reset();
            return;
        end
        if (Hold) return;
        if (cyc_op >= 0 && carry_op(cyc_op, cyc_is_hi)) e_flagc = AluCarryOut;
        if (pend_hi_op >= 0) begin
            e_chain = AluCarryOut;
            show(pend_hi_op, 1);
            pend_hi_op = -1;
        end else if (OpValid && AluOp != 0) begin
            show(int'(AluOp), 0);
            if (AluOp == 13 || AluOp == 14) pend_hi_op = int'(AluOp);
        end else begin
            show(-1, 0);
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("AluCtrl",     AluCtrl,            e_ctrl);
        chk("Stall",       {7'd0, Stall},      {7'd0, e_stall});
        chk("AluClockEn",  {7'd0, AluClockEn}, {7'd0, e_clken});
        chk("AluActive",   {7'd0, AluActive},  {7'd0, e_active});
        chk("AluWrite",    {7'd0, AluWrite},   {7'd0, e_write});
        chk("AluHighByte", {7'd0, AluHighByte},{7'd0, e_high});
        chk("ChainCarry",  {7'd0, ChainCarry}, {7'd0, e_chain});
        chk("FlagC",       {7'd0, FlagC},      {7'd0, e_flagc});
    endtask

    task automatic cyc(input logic v, input logic [3:0] op, input logic c, input logic h);
        OpValid = v; AluOp = op; AluCarryOut = c; Hold = h;
        @(posedge Clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        Reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Hold = 0; OpValid = 0; AluOp = '0; AluCarryOut = 0;
        model_reset();
        #2;
        check_all();
        chk("reset_flagc_const", {7'd0, FlagC}, 8'h01);
        @(negedge Clock);
        Reset = 1'b0;

        // NOP after reset stays inactive
        cyc(1, 4'd0, 0, 0);
        chk("nop_inactive", {7'd0, AluActive}, 8'h00);

        // ADD, XOR, CMP back to back; carry only during XOR cycle
        cyc(1, 4'd1, 0, 0);
        chk("add_word", AluCtrl, 8'h0A);
        cyc(1, 4'd7, 0, 0);
        chk("xor_word", AluCtrl, 8'h16);
        cyc(1, 4'd15, 1, 0);
        chk("cmp_word", AluCtrl, 8'h45);
        chk("cmp_nowrite", {7'd0, AluWrite}, 8'h00);
        chk("flagc_after_xor", {7'd0, FlagC}, 8'h00);
        cyc(0, 4'd0, 0, 0);

        // ADD16 with carry out of the low step
        cyc(1, 4'd13, 0, 0);
        chk("add16_lo", AluCtrl, 8'h0A);
        chk("add16_stall", {7'd0, Stall}, 8'h01);
        cyc(1, 4'd13, 1, 0);
        chk("add16_hi", AluCtrl, 8'hCA);
        chk("add16_chain", {7'd0, ChainCarry}, 8'h01);
        chk("add16_flag_unchanged", {7'd0, FlagC}, 8'h00);
        cyc(0, 4'd0, 1, 0);
        chk("add16_flag_after_hi", {7'd0, FlagC}, 8'h01);

        // SUB16 with hold while the low word is displayed
        cyc(1, 4'd14, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'd14, 1, 1);
            chk("sub16_hold_word", AluCtrl, 8'h45);
        end
        cyc(1, 4'd14, 0, 0);
        chk("sub16_hi", AluCtrl, 8'hC5);
        cyc(0, 4'd0, 0, 0);
        chk("sub16_hi_once", AluCtrl, 8'h00);

        // ADC then SBC, carry flag following each cycle
        cyc(1, 4'd1, 0, 0);
        cyc(1, 4'd2, 1, 0);
        chk("adc_word", AluCtrl, 8'h8A);
        cyc(1, 4'd4, 0, 0);
        chk("sbc_word", AluCtrl, 8'h85);
        cyc(0, 4'd0, 1, 0);

        // Reset during the ADD16 stall cycle aborts the high step
        cyc(1, 4'd13, 0, 0);
        async_reset();
        chk("abort_stall", {7'd0, Stall}, 8'h00);
        cyc(1, 4'd11, 0, 0);
        chk("post_abort_inc", AluCtrl, 8'h40);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(99) < 3) begin
                async_reset();
            end else begin
                cyc(1'($urandom_range(99) < 80), 4'($urandom_range(15)),
                    1'($urandom_range(1)), 1'($urandom_range(99) < 10));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sits between pipeline stage 1 (ALU op field) and the ALU; registers the 4-bit ALU op and decodes it into the 8-bit ALU control word {CS[1:0], LHS[1:0], RHS[3:0]}.
- Generates AluActive, AluWrite and the ALU clock enable, and holds the carry flag.
- Splits 16-bit ADD16/SUB16 into two chained 8-bit cycles: low byte, then high byte with internal carry. Stalls the upstream pipe for one cycle while doing so.

Parameters:
- RESET_FLAGC, 0, reset value of the FlagC register.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Hold  in  1  global pipeline hold; freezes all state.
- OpValid  in  1  stage-1 op present.
- AluOp  in  4  stage-1 ALU op (Pipe1Out[7:4]).
- AluCarryOut  in  1  ALU carry out of the current cycle.
- Stall  out  1  registered; upstream must not advance while 1.
- AluClockEn  out  1  ALU register clock enable.
- AluActive  out  1  ALU result drives bus this cycle.
- AluWrite  out  1  result is written back (0 for CMP).
- AluHighByte  out  1  selects high operand bytes (16-bit high step).
- AluCtrl  out  8  {CS[1:0], LHS[1:0], RHS[3:0]} = AC7..AC0.
- ChainCarry  out  1  latched low-step carry, used when CS=11.
- FlagC  out  1  architectural carry flag.

Behaviour:
- CS encoding: 00 = carry-in 0; 01 = carry-in 1; 10 = FlagC; 11 = ChainCarry.
- Decode (op: AluCtrl):
  - 0 NOP: 00, inactive.
  - 1 ADD: 0A. 2 ADC: 8A. 3 SUB: 45. 4 SBC: 85.
  - 5 AND: 18. 6 OR: 1E. 7 XOR: 16. 8 NOT: 10.
  - 9 SHL: 2F. 10 SHR: 30. 11 INC: 40. 12 DEC: 0F.
  - 13 ADD16: lo 0A, hi CA. 14 SUB16: lo 45, hi C5.
  - 15 CMP: 45, AluWrite=0.
- States: IDLE, HI16. All outputs are registered.
- Reset: state=IDLE, Stall=0, AluClockEn=0, AluActive=0, AluWrite=0, AluHighByte=0, AluCtrl=00, ChainCarry=0, FlagC=RESET_FLAGC.
- Hold=1: no register changes, including state, outputs, ChainCarry and FlagC. Hold overrides everything except Reset.
- IDLE, edge with OpValid=1 and op 1..12 or 15: next cycle shows the decoded word, AluActive=1, AluClockEn=1, AluWrite=1 (0 for op 15), AluHighByte=0. Latency is 1 clock.
- IDLE, OpValid=0 or op 0: next cycle AluActive=0, AluClockEn=0, AluWrite=0, AluCtrl=00.
- IDLE, edge with op 13/14:
  - Next cycle: lo word, AluActive=1, AluWrite=1, AluHighByte=0, Stall=1; state goes to HI16.
- HI16, edge:
  - ChainCarry <= AluCarryOut.
  - Next cycle: hi word, AluHighByte=1, AluActive=1, AluWrite=1, Stall=0; state goes to IDLE.
  - OpValid/AluOp are ignored on this edge; upstream presents the same op again, which is accepted on the following edge.
- FlagC <= AluCarryOut on each non-held edge that ends a cycle with AluActive=1 and an op in {ADD, ADC, SUB, SBC, SHL, SHR, INC, DEC, ADD16 hi, SUB16 hi, CMP}.
- FlagC is unchanged for AND/OR/XOR/NOT, NOP and 16-bit lo steps.
- Back-to-back single-cycle ops issue every clock with no bubble.
- Back-to-back 16-bit ops give a 2-cycle period per op.
- Reset asserted mid-16-bit op aborts to IDLE immediately. No hi step is issued. Stall drops asynchronously.
- Hold during HI16 keeps Stall=1 and the lo word on the outputs until Hold is released.

Test Plan:
- Reset with RESET_FLAGC=1 → all outputs 0, FlagC=1; release; NOP → AluActive=0.
- ADD then XOR then CMP on consecutive edges:
  - AluCtrl=0A, 16, 45 on the next three cycles, AluWrite=1,1,0.
  - With AluCarryOut=1 during the XOR cycle only, FlagC stays at its prior value.
- ADD16 with AluCarryOut=1 in the lo cycle:
  - Lo cycle: AluCtrl=0A, Stall=1.
  - Next cycle: AluCtrl=CA, AluHighByte=1, ChainCarry=1, Stall=0.
  - FlagC updated only after the hi cycle.
- SUB16, then Hold=1 for 3 cycles while in HI16 → Stall and AluCtrl=45 frozen; after release, C5 issues exactly once.
- ADC with FlagC=1 → AluCtrl=8A. Then SBC → 85. FlagC follows AluCarryOut of each cycle.
- Assert Reset during the Stall cycle of ADD16 → Stall=0 and AluActive=0 without waiting for a clock; next op issues normally from IDLE.
